// File: rtl/l2_arb_pkg.sv
// Shared definitions for the L2 port arbiter: state encodings, port ids, default widths.
package l2_arb_pkg;

  localparam int ADDRLEN_DEF = 30;
  localparam int LINELEN_DEF = 128;
  localparam int CNTLEN_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2
  } arb_state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing the single L2 port between the I and D L1 miss interfaces.
// A grant is held for the whole L2 transaction; per-port grant counters feed statistics.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no owner, L2 outputs quiet, arbitrating pending requests
// ST_GRANT_I | port I owns L2; its request is forwarded until l2_ready
// ST_GRANT_D | port D owns L2; its request is forwarded until l2_ready
module l2_port_arbiter
  import l2_arb_pkg::*;
#(
  parameter int ADDRLEN = ADDRLEN_DEF,
  parameter int LINELEN = LINELEN_DEF,
  parameter int CNTLEN  = CNTLEN_DEF
) (
  input  logic               clk,
  input  logic               proc_reset,
  input  logic               i_read,
  input  logic               i_write,
  input  logic [ADDRLEN-1:0] i_addr,
  input  logic [LINELEN-1:0] i_wdata,
  output logic [LINELEN-1:0] i_rdata,
  output logic               i_ready,
  output logic               i_stall,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDRLEN-1:0] d_addr,
  input  logic [LINELEN-1:0] d_wdata,
  output logic [LINELEN-1:0] d_rdata,
  output logic               d_ready,
  output logic               d_stall,
  output logic               l2_read,
  output logic               l2_write,
  output logic [ADDRLEN-1:0] l2_addr,
  output logic [LINELEN-1:0] l2_wdata,
  input  logic [LINELEN-1:0] l2_rdata,
  input  logic               l2_ready,
  output logic [CNTLEN-1:0]  i_grants,
  output logic [CNTLEN-1:0]  d_grants
);

  arb_state_e        state_q, state_d;
  logic              last_owner_q;
  logic [CNTLEN-1:0] i_grants_q, d_grants_q;
  logic              req_i, req_d;
  logic              grant_i, grant_d;

  assign req_i = i_read | i_write;
  assign req_d = d_read | d_write;

  // Read data is broadcast; each requester only consumes it alongside its own ready.
  assign i_rdata  = l2_rdata;
  assign d_rdata  = l2_rdata;
  assign i_grants = i_grants_q;
  assign d_grants = d_grants_q;

  // State register, round-robin history and grant counters.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q      <= ST_IDLE;
      last_owner_q <= PORT_I;
      i_grants_q   <= '0;
      d_grants_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant_i) begin
        last_owner_q <= PORT_I;
        i_grants_q   <= i_grants_q + CNTLEN'(1);
      end else if (grant_d) begin
        last_owner_q <= PORT_D;
        d_grants_q   <= d_grants_q + CNTLEN'(1);
      end
    end
  end

  // Next-state arbitration, L2 request forwarding and completion pulses.
  always_comb begin
    state_d  = state_q;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    l2_read  = 1'b0;
    l2_write = 1'b0;
    l2_addr  = '0;
    l2_wdata = '0;
    i_ready  = 1'b0;
    d_ready  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_i && req_d) begin
          // Tie goes to whichever port did not own L2 last.
          if (last_owner_q == PORT_I) grant_d = 1'b1;
          else                        grant_i = 1'b1;
        end else begin
          grant_i = req_i;
          grant_d = req_d;
        end
        if (grant_i)      state_d = ST_GRANT_I;
        else if (grant_d) state_d = ST_GRANT_D;
      end
      ST_GRANT_I: begin
        // Simultaneous read+write is illegal; the read wins.
        l2_read  = i_read;
        l2_write = i_write & ~i_read;
        l2_addr  = i_addr;
        l2_wdata = i_wdata;
        if (l2_ready) begin
          i_ready = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_GRANT_D: begin
        l2_read  = d_read;
        l2_write = d_write & ~d_read;
        l2_addr  = d_addr;
        l2_wdata = d_wdata;
        if (l2_ready) begin
          d_ready = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Gated by reset so the stall lines are quiet while the block is held in reset.
    i_stall = req_i & ~i_ready & ~proc_reset;
    d_stall = req_d & ~d_ready & ~proc_reset;
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter: arbitration order, hold-until-ready, reset abandon,
// and counter wrap (on a narrow-counter instance so the wrap is reachable quickly).
module tb_l2_port_arbiter;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         i_read, i_write, d_read, d_write, l2_ready;
  logic [29:0]  i_addr, d_addr;
  logic [127:0] i_wdata, d_wdata, l2_rdata;
  logic [127:0] i_rdata, d_rdata, l2_wdata;
  logic         i_ready, i_stall, d_ready, d_stall, l2_read, l2_write;
  logic [29:0]  l2_addr;
  logic [15:0]  i_grants, d_grants;

  logic [127:0] w4_i_rdata, w4_d_rdata, w4_l2_wdata;
  logic         w4_i_ready, w4_i_stall, w4_d_ready, w4_d_stall, w4_l2_read, w4_l2_write;
  logic [29:0]  w4_l2_addr;
  logic [3:0]   w4_i_grants, w4_d_grants;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  l2_port_arbiter dut (
    .clk(clk), .proc_reset(proc_reset),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready), .i_stall(i_stall),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
    .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_ready(l2_ready),
    .i_grants(i_grants), .d_grants(d_grants)
  );

  l2_port_arbiter #(.CNTLEN(4)) u_dut_w4 (
    .clk(clk), .proc_reset(proc_reset),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(w4_i_rdata), .i_ready(w4_i_ready), .i_stall(w4_i_stall),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(w4_d_rdata), .d_ready(w4_d_ready), .d_stall(w4_d_stall),
    .l2_read(w4_l2_read), .l2_write(w4_l2_write), .l2_addr(w4_l2_addr),
    .l2_wdata(w4_l2_wdata), .l2_rdata(l2_rdata), .l2_ready(l2_ready),
    .i_grants(w4_i_grants), .d_grants(w4_d_grants)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    proc_reset = 1'b1;
    tick();
    tick();
    proc_reset = 1'b0;
  endtask

  // One I read: request raised in IDLE, granted next edge, completed in the grant cycle.
  task automatic txn_i();
    i_read = 1'b1;
    tick();
    i_read   = 1'b0;
    l2_ready = 1'b1;
    tick();
    l2_ready = 1'b0;
  endtask

  initial begin
    i_read = 0; i_write = 0; d_read = 0; d_write = 0; l2_ready = 0;
    i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0; l2_rdata = '0;
    proc_reset = 1'b1;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_l2_read",  l2_read,  0);
    check("rst_l2_write", l2_write, 0);
    check("rst_readies",  {i_ready, d_ready, i_stall, d_stall}, 0);
    check("rst_grants",   {i_grants, d_grants}, 0);

    // 1. Single D read, L2 ready in the third grant cycle
    tick();
    d_read = 1'b1; d_addr = 30'h0000_0ABC;
    @(negedge clk);
    check("t1_latency_l2_read", l2_read, 0);
    check("t1_d_stall", d_stall, 1);
    tick();
    @(negedge clk);
    check("t1_l2_read", l2_read, 1);
    check("t1_l2_addr", l2_addr, 30'h0000_0ABC);
    check("t1_d_grants", d_grants, 1);
    tick();
    tick();
    l2_ready = 1'b1; l2_rdata = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
    @(negedge clk);
    check("t1_d_ready", d_ready, 1);
    check("t1_d_rdata", d_rdata, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D);
    check("t1_i_ready", i_ready, 0);
    check("t1_d_stall_done", d_stall, 0);
    tick();
    d_read = 1'b0; l2_ready = 1'b0;
    @(negedge clk);
    check("t1_idle_l2_read", l2_read, 0);
    check("t1_d_ready_gone", d_ready, 0);
    check("t1_state_idle", dut.state_q, 0);

    // 2. Simultaneous I and D after reset: D first, one IDLE cycle, then I
    tick();
    do_reset();
    i_read = 1'b1; i_addr = 30'h111;
    d_read = 1'b1; d_addr = 30'h222;
    @(negedge clk);
    check("t2_idle_l2_read", l2_read, 0);
    tick();
    l2_ready = 1'b1;
    @(negedge clk);
    check("t2_first_owner_d", l2_addr, 30'h222);
    check("t2_d_ready", d_ready, 1);
    check("t2_i_ready", i_ready, 0);
    check("t2_i_stall", i_stall, 1);
    tick();
    l2_ready = 1'b0; d_read = 1'b0;
    @(negedge clk);
    check("t2_gap_idle", dut.state_q, 0);
    check("t2_gap_l2_read", l2_read, 0);
    tick();
    l2_ready = 1'b1;
    @(negedge clk);
    check("t2_second_owner_i", l2_addr, 30'h111);
    check("t2_i_ready", i_ready, 1);
    tick();
    l2_ready = 1'b0; i_read = 1'b0;
    @(negedge clk);
    check("t2_grants", {i_grants, d_grants}, {16'd1, 16'd1});

    // 3. Sustained D write-back and I read: D,I,D,I,D,I
    tick();
    d_write = 1'b1; d_addr = 30'h333; d_wdata = 128'h5555;
    i_read  = 1'b1; i_addr = 30'h444;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t3_idle_quiet", {l2_read, l2_write}, 0);
      tick();
      l2_ready = 1'b1;
      @(negedge clk);
      check("t3_owner_addr", l2_addr, (k % 2 == 0) ? 30'h333 : 30'h444);
      check("t3_l2_write", l2_write, (k % 2 == 0));
      check("t3_l2_read", l2_read, (k % 2 != 0));
      check("t3_d_ready", d_ready, (k % 2 == 0));
      check("t3_i_ready", i_ready, (k % 2 != 0));
      if (k % 2 == 0) check("t3_l2_wdata", l2_wdata, 128'h5555);
      tick();
      l2_ready = 1'b0;
    end
    d_write = 1'b0; i_read = 1'b0;
    @(negedge clk);
    check("t3_grants", {i_grants, d_grants}, {16'd4, 16'd4});

    // 4. l2_ready in IDLE is ignored; grant held after owner drops request
    tick();
    l2_ready = 1'b1;
    @(negedge clk);
    check("t4_stray_ready", {i_ready, d_ready}, 0);
    tick();
    l2_ready = 1'b0;
    @(negedge clk);
    check("t4_still_idle", dut.state_q, 0);
    tick();
    i_read = 1'b1; i_addr = 30'h555;
    tick();
    i_read = 1'b0;
    @(negedge clk);
    check("t4_granted_i", dut.state_q, 1);
    check("t4_l2_read_follows", l2_read, 0);
    check("t4_i_stall_dropped", i_stall, 0);
    tick();
    @(negedge clk);
    check("t4_grant_held", dut.state_q, 1);
    tick();
    l2_ready = 1'b1;
    @(negedge clk);
    check("t4_i_ready", i_ready, 1);
    tick();
    l2_ready = 1'b0;
    @(negedge clk);
    check("t4_back_idle", dut.state_q, 0);
    check("t4_i_grants", i_grants, 5);

    // 5. Reset during GRANT_I abandons the transaction
    tick();
    i_read = 1'b1; i_addr = 30'h666;
    tick();
    @(negedge clk);
    check("t5_granted", l2_read, 1);
    tick();
    proc_reset = 1'b1; i_read = 1'b0;
    tick();
    proc_reset = 1'b0; l2_ready = 1'b1;
    @(negedge clk);
    check("t5_outputs", {l2_read, l2_write, l2_addr, i_ready, d_ready, i_stall, d_stall}, 0);
    check("t5_counters", {i_grants, d_grants}, 0);
    check("t5_state", dut.state_q, 0);
    tick();
    l2_ready = 1'b0;
    @(negedge clk);
    check("t5_no_late_ready", i_ready, 0);

    // 6. Counter wrap at all-ones (4-bit instance alongside the 16-bit one)
    tick();
    do_reset();
    for (int k = 0; k < 15; k++) txn_i();
    @(negedge clk);
    check("t6_w4_allones", w4_i_grants, 4'hF);
    tick();
    txn_i();
    @(negedge clk);
    check("t6_w4_wrap", w4_i_grants, 4'h0);
    check("t6_w16_count", i_grants, 16);
    check("t6_w4_d_untouched", w4_d_grants, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
